lin_interp: RTL and testbench

LIN_INTERP -- requirements
Module: lin_interp

---
 rtl/lin_interp_pkg.sv | 13 +
 rtl/lin_interp.sv | 109 ++++++++++
 tb/tb_lin_interp.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lin_interp_pkg.sv
// Shared constants for the linear interpolating upsampler: FSM state
// encoding and the default upsampling exponent.
package lin_interp_pkg;

  localparam int LOG2_N_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/lin_interp.sv
// Linear interpolating upsampler: emits N = 2^LOG2_N samples per input
// sample, stepping from prev toward cur with floor rounding.
module lin_interp
  import lin_interp_pkg::*;
#(
  parameter int LOG2_N = LOG2_N_DEFAULT
) (
  input  logic               i_clock,
  input  logic               i_RESET,
  input  logic signed [31:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic signed [31:0] o_data,
  output logic               o_valid,
  output logic               o_underrun
);

  localparam int AW = 34 + LOG2_N;
  localparam logic [LOG2_N-1:0] K_LAST = '1;

  // Handshake: a sample is taken on a rising edge where i_valid && o_ready;
  // o_ready depends only on registered state, never on i_valid.

  state_t             state;
  state_t             state_next;
  logic signed [31:0] prev;
  logic signed [31:0] cur;
  logic signed [31:0] buf_data;
  logic               buf_full;
  logic [LOG2_N-1:0]  k;
  logic signed [AW-1:0] acc;
  logic signed [32:0] diff;
  logic               underrun;

  logic               accept;
  logic               seg_last;
  logic               start_seg;
  logic signed [31:0] new_sample;

  assign o_ready    = (state == ST_RUN) ? ~buf_full : 1'b1;
  assign accept     = i_valid && o_ready;
  assign seg_last   = (state == ST_RUN) && (k == K_LAST);
  // Buffered sample takes priority; when the buffer is empty the input bypasses it.
  assign new_sample = buf_full ? buf_data : i_data;
  assign start_seg  = ((state == ST_PRIME) && accept) ||
                      (seg_last && (buf_full || accept));

  // acc is left untouched when a segment ends without a successor, so o_data holds.
  assign o_data     = acc[LOG2_N +: 32];
  assign o_valid    = (state == ST_RUN);
  assign o_underrun = underrun;

  logic unused_bits;
  assign unused_bits = ^{acc[AW-1:LOG2_N+32], acc[LOG2_N-1:0], prev};

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (accept) state_next = ST_PRIME;
      ST_PRIME: if (accept) state_next = ST_RUN;
      ST_RUN:   if (seg_last && !buf_full && !accept) state_next = ST_PRIME;
      default:  state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      prev     <= '0;
      cur      <= '0;
      buf_data <= '0;
      buf_full <= 1'b0;
      k        <= '0;
      acc      <= '0;
      diff     <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= seg_last && !buf_full && !accept;
      if ((state == ST_EMPTY) && accept) begin
        cur <= i_data;
      end
      if (start_seg) begin
        prev     <= cur;
        cur      <= new_sample;
        acc      <= {{(AW-32){cur[31]}}, cur} << LOG2_N;
        diff     <= {new_sample[31], new_sample} - {cur[31], cur};
        k        <= '0;
        buf_full <= 1'b0;
      end else if (state == ST_RUN) begin
        if (!seg_last) begin
          acc <= acc + {{(AW-33){diff[32]}}, diff};
          k   <= k + LOG2_N'(1);
        end
        if (accept) begin
          buf_data <= i_data;
          buf_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lin_interp.sv
// Bench for lin_interp at N=4: arithmetic reference model with a per-cycle
// compare process, plus directed vectors with literal expectations.
module tb_lin_interp;

  localparam int LOG2_N = 2;
  localparam int N      = 1 << LOG2_N;

  // clock / reset
  logic               clock   = 1'b0;
  logic               i_RESET = 1'b0;
  logic signed [31:0] i_data  = '0;
  logic               i_valid = 1'b0;
  logic               o_ready;
  logic               o_valid;
  logic               o_underrun;
  logic signed [31:0] o_data;

  always #5 clock = ~clock;

  lin_interp #(.LOG2_N(LOG2_N)) dut (
    .i_clock   (clock),
    .i_RESET   (i_RESET),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_underrun(o_underrun)
  );

  typedef struct {
    logic               v;
    logic               u;
    logic               r;
    logic signed [31:0] d;
  } obs_t;

  obs_t               log_q[$];
  logic [31:0]        exp_q[$];
  logic signed [31:0] last_out = '0;
  logic signed [31:0] last_in  = '0;
  bit                 have_in  = 1'b0;
  int                 n_checks = 0;
  int                 n_errs   = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // reference model: each new sample closes a segment from the previous one
  function automatic void model_accept(input logic signed [31:0] x);
    longint d, kd, q;
    if (have_in) begin
      d = longint'(x) - longint'(last_in);
      for (int kk = 0; kk < N; kk++) begin
        kd = kk * d;
        q  = kd / N;
        if ((kd % N != 0) && (kd < 0)) q = q - 1;
        exp_q.push_back(32'(longint'(last_in) + q));
      end
    end
    last_in = x;
    have_in = 1'b1;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    last_out = '0;
    last_in  = '0;
    have_in  = 1'b0;
  endfunction

  // scoreboard compare, every falling edge while out of reset
  always @(negedge clock) begin
    obs_t               ob;
    logic signed [31:0] e;
    if (i_RESET) begin
      ob.v = o_valid;
      ob.u = o_underrun;
      ob.r = o_ready;
      ob.d = o_data;
      log_q.push_back(ob);
      if (o_valid) begin
        check("valid_no_underrun", o_underrun, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", o_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("stream_data", o_data, e);
          last_out = e;
        end
      end else begin
        check("hold_data", o_data, last_out);
      end
    end
  end

  // driver tasks
  task automatic send(input logic signed [31:0] x);
    int waited = 0;
    i_data  = x;
    i_valid = 1'b1;
    while (!o_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    check("send_accept", o_ready, 1);
    if (o_ready) begin
      model_accept(x);
      @(posedge clock);
      @(negedge clock);
    end
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    i_RESET = 1'b0;
    model_reset();
    log_q.delete();
    repeat (2) @(negedge clock);
    i_RESET = 1'b1;
  endtask

  function automatic int first_valid(input int from);
    for (int i = from; i < log_q.size(); i++) begin
      if (i >= 0 && log_q[i].v) return i;
    end
    return -1;
  endfunction

  function automatic obs_t obs_at(input int i);
    obs_t o;
    o.v = 1'bx;
    o.u = 1'bx;
    o.r = 1'bx;
    o.d = 'x;
    if (i >= 0 && i < log_q.size()) o = log_q[i];
    return o;
  endfunction

  task automatic check_seg(input string nm, input int f,
                           input logic signed [31:0] a, input logic signed [31:0] b,
                           input logic signed [31:0] c, input logic signed [31:0] dd);
    logic signed [31:0] ev[4];
    obs_t o;
    ev[0] = a; ev[1] = b; ev[2] = c; ev[3] = dd;
    for (int i = 0; i < 4; i++) begin
      o = obs_at(f + i);
      check({nm, "_valid"}, o.v, 1);
      check({nm, "_data"}, o.d, ev[i]);
    end
  endtask

  initial begin
    int   f;
    int   g;
    bit   seen;
    obs_t o;

    #1;
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_underrun", o_underrun, 0);
    repeat (2) @(negedge clock);
    i_RESET = 1'b1;

    // back-to-back ramp
    do_reset();
    send(0);
    send(100);
    #1;
    check("first_valid_latency", o_valid, 1);
    check("first_valid_data", o_data, 0);
    send(200);
    idle(12);
    f = first_valid(0);
    check_seg("ramp_a", f, 0, 25, 50, 75);
    check_seg("ramp_b", f + 4, 100, 125, 150, 175);
    o = obs_at(f + 8);
    check("ramp_end_valid", o.v, 0);
    check("ramp_end_underrun", o.u, 1);
    check("ramp_end_hold", o.d, 175);
    o = obs_at(f + 9);
    check("ramp_underrun_one_cycle", o.u, 0);

    // floor rounding on a negative step
    do_reset();
    send(0);
    send(-10);
    idle(8);
    check_seg("floor_neg", first_valid(0), 0, -3, -5, -8);

    // full-scale swing without wrap
    do_reset();
    send(32'sh7FFFFFFF);
    send(32'sh80000000);
    idle(8);
    check_seg("extreme", first_valid(0), 2147483647, 1073741823, -1, -1073741825);

    // underrun then resume
    do_reset();
    send(0);
    send(100);
    idle(8);
    f = first_valid(0);
    check_seg("underrun_seg", f, 0, 25, 50, 75);
    o = obs_at(f + 4);
    check("underrun_pulse", o.u, 1);
    check("underrun_ready", o.r, 1);
    o = obs_at(f + 5);
    check("underrun_single", o.u, 0);
    o = obs_at(f + 6);
    check("underrun_hold", o.d, 75);
    send(200);
    idle(8);
    g = first_valid(f + 4);
    check_seg("resume", g, 100, 125, 150, 175);

    // third sample arrives exactly on the last step of a segment
    do_reset();
    send(0);
    send(100);
    idle(3);
    send(200);
    idle(10);
    f = first_valid(0);
    check_seg("bypass_a", f, 0, 25, 50, 75);
    check_seg("bypass_b", f + 4, 100, 125, 150, 175);

    // producer faster than consumer: buffer fills, o_ready drops
    do_reset();
    send(0);
    send(100);
    send(200);
    send(300);
    idle(14);
    f = first_valid(0);
    check_seg("bp_a", f, 0, 25, 50, 75);
    check_seg("bp_b", f + 4, 100, 125, 150, 175);
    check_seg("bp_c", f + 8, 200, 225, 250, 275);
    seen = 1'b0;
    foreach (log_q[i]) if (log_q[i].r === 1'b0) seen = 1'b1;
    check("backpressure_seen", seen, 1);

    // asynchronous reset in the middle of a segment
    do_reset();
    send(0);
    send(100);
    idle(2);
    #2;
    i_RESET = 1'b0;
    #1;
    check("async_rst_valid", o_valid, 0);
    check("async_rst_data", o_data, 0);
    check("async_rst_underrun", o_underrun, 0);
    check("async_rst_ready", o_ready, 1);
    model_reset();
    log_q.delete();
    repeat (2) @(negedge clock);
    i_RESET = 1'b1;
    send(500);
    idle(4);
    check("one_sample_no_valid", first_valid(0), -1);
    send(600);
    idle(6);
    check_seg("after_reset", first_valid(0), 500, 525, 550, 575);

    check("model_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
